accum_dump_sat: RTL and testbench

- Integrate-and-dump accumulator directly downstream of the DSP multiply/convergent-rounding stage.
- Consumes its signed 24-bit rounded product stream, sums DUMP_LEN accepted samples, and applies an optional arithmetic right shift.
- Saturates the result to OUT_W bits and presents it on a registered valid/ready output with a saturation flag and a sticky overflow flag.

---
 rtl/dsp_pkg.sv | 39 +++
 rtl/sat_shift.sv | 33 +++
 rtl/accum_dump_sat.sv | 129 ++++++++++++
 tb/tb_accum_dump_sat.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: common sample widths, output register state and the
// signed saturation helper used by the shift/clamp stages.
package dsp_pkg;

  localparam int DSP_IN_W  = 24;
  localparam int DSP_OUT_W = 24;
  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic                        sat;
    logic signed [SAT_MAX_W-1:0] value;
  } sat_res_t;

  // Clamp a wide signed value into the range of an out_w-bit signed number.
  function automatic sat_res_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                          input int out_w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_res_t                    res;
    hi        = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo        = ~hi;
    res.sat   = 1'b0;
    res.value = value;
    if (value > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (value < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift followed by signed saturation to OUT_W.
// Reusable by any DSP stage that narrows a wide accumulator.
module sat_shift
  import dsp_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int SHIFT = 0,
  parameter int OUT_W = 24
) (
  input  logic signed [ACC_W-1:0] i_value,
  output logic signed [OUT_W-1:0] o_value,
  output logic                    o_sat
);

  if (ACC_W > SAT_MAX_W || OUT_W > ACC_W) begin : g_bad_width
    $error("sat_shift: widths out of range");
  end
  if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_shift
    $error("sat_shift: SHIFT out of range");
  end

  logic signed [ACC_W-1:0]     w_shifted;
  logic signed [SAT_MAX_W-1:0] w_wide;
  sat_res_t                    w_res;

  // >>> on a signed operand floors toward -inf.
  assign w_shifted = i_value >>> SHIFT;
  assign w_wide    = SAT_MAX_W'(w_shifted);
  assign w_res     = sat_signed(w_wide, OUT_W);
  assign o_value   = w_res.value[OUT_W-1:0];
  assign o_sat     = w_res.sat;

endmodule

// File: rtl/accum_dump_sat.sv
// Integrate-and-dump accumulator: sums DUMP_LEN accepted samples, shifts and
// saturates the sum, and holds it in a one-entry valid/ready output register.
module accum_dump_sat
  import dsp_pkg::*;
#(
  parameter int IN_W     = DSP_IN_W,
  parameter int DUMP_LEN = 16,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = DSP_OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic signed [IN_W-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [OUT_W-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_sat,
  output logic                   ovf_sticky
);

  localparam int CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;

  if (DUMP_LEN < 2 || DUMP_LEN > 1024) begin : g_bad_len
    $error("accum_dump_sat: DUMP_LEN must be 2..1024");
  end
  if (ACC_W < IN_W + $clog2(DUMP_LEN)) begin : g_bad_acc
    $error("accum_dump_sat: ACC_W too narrow for IN_W and DUMP_LEN");
  end

  // Handshakes: a sample moves when din_valid & din_ready, a result when
  // dout_valid & dout_ready; a dump and a pop in one cycle replace the entry.
  out_state_t              r_state;
  out_state_t              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0]        r_dout;
  logic                    r_dout_sat;
  logic                    r_ovf;

  logic                    w_last;
  logic                    w_accept;
  logic                    w_dump;
  logic                    w_pop;
  logic signed [ACC_W-1:0] w_din_ext;
  logic signed [ACC_W-1:0] w_acc_in;
  logic signed [OUT_W-1:0] w_sat_value;
  logic                    w_sat_flag;

  assign w_last    = (r_cnt == CNT_W'(DUMP_LEN - 1));
  // Only the frame-completing sample has to wait for room in the output register.
  assign din_ready = !rst && !clear && !(w_last && (r_state == OUT_FULL) && !dout_ready);
  assign w_accept  = din_valid && din_ready;
  assign w_dump    = w_accept && w_last;
  assign w_pop     = (r_state == OUT_FULL) && dout_ready;
  assign w_din_ext = ACC_W'(din);
  assign w_acc_in  = (r_cnt == '0) ? w_din_ext : (r_acc + w_din_ext);

  sat_shift #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_sat_shift (
    .i_value (w_acc_in),
    .o_value (w_sat_value),
    .o_sat   (w_sat_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
      r_acc <= w_last ? '0 : w_acc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_dump) w_state_nxt = OUT_FULL;
      OUT_FULL:  if (w_pop && !w_dump) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    dout_valid = (r_state == OUT_FULL);
    dout       = r_dout;
    dout_sat   = r_dout_sat;
    ovf_sticky = r_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_sat <= 1'b0;
    end else if (w_dump) begin
      r_dout     <= w_sat_value;
      r_dout_sat <= w_sat_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_dump && w_sat_flag) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_dump_sat.sv
// Bench for accum_dump_sat with DUMP_LEN=4: one DUT with SHIFT=0 and one with
// SHIFT=2 share all inputs; a frame-sum model predicts every output.
module tb_accum_dump_sat;

  localparam int DUMP_LEN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic signed [23:0] din;
  logic              din_valid;
  logic              dout_ready;
  logic              rdy0, rdy2, dv0, dv2, sat0, sat2, ovf0, ovf2;
  logic [23:0]       dout0, dout2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum_dump_sat #(.IN_W(24), .DUMP_LEN(DUMP_LEN), .ACC_W(40), .SHIFT(0), .OUT_W(24)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
    .dout_sat(sat0), .ovf_sticky(ovf0)
  );

  accum_dump_sat #(.IN_W(24), .DUMP_LEN(DUMP_LEN), .ACC_W(40), .SHIFT(2), .OUT_W(24)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .din(din), .din_valid(din_valid),
    .din_ready(rdy2), .dout(dout2), .dout_valid(dv2), .dout_ready(dout_ready),
    .dout_sat(sat2), .ovf_sticky(ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor-shift the frame sum, then clamp to 24-bit signed. Returns {sat, value}.
  function automatic logic [24:0] expect_out(input longint sum, input int sh);
    longint v;
    v = sum >>> sh;
    if (v > 64'sd8388607)       return {1'b1, 24'h7FFFFF};
    else if (v < -64'sd8388608) return {1'b1, 24'h800000};
    else                        return {1'b0, v[23:0]};
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [24:0] exp_q0[$];
  logic [24:0] exp_q2[$];
  longint      m_sum = 0;
  int          m_n = 0;
  logic        m_ovf0 = 1'b0;
  logic        m_ovf2 = 1'b0;

  always @(negedge clk) begin
    logic        exp_rdy;
    logic [24:0] e0, e2;
    if (rst) begin
      exp_q0.delete();
      exp_q2.delete();
      m_sum = 0; m_n = 0; m_ovf0 = 1'b0; m_ovf2 = 1'b0;
      check("rst_din_ready", {31'b0, rdy0 | rdy2}, 32'd0);
      check("rst_dout_valid", {31'b0, dv0 | dv2}, 32'd0);
      check("rst_ovf", {31'b0, ovf0 | ovf2}, 32'd0);
      check("rst_dout0", {8'b0, dout0}, 32'd0);
    end else begin
      exp_rdy = !clear && !(m_n == DUMP_LEN - 1 && exp_q0.size() != 0 && !dout_ready);
      check("mon_din_ready0", {31'b0, rdy0}, {31'b0, exp_rdy});
      check("mon_din_ready2", {31'b0, rdy2}, {31'b0, exp_rdy});
      check("mon_dout_valid0", {31'b0, dv0}, {31'b0, exp_q0.size() != 0});
      check("mon_dout_valid2", {31'b0, dv2}, {31'b0, exp_q2.size() != 0});
      if (exp_q0.size() != 0) begin
        check("mon_dout0", {8'b0, dout0}, {8'b0, exp_q0[0][23:0]});
        check("mon_sat0", {31'b0, sat0}, {31'b0, exp_q0[0][24]});
      end
      if (exp_q2.size() != 0) begin
        check("mon_dout2", {8'b0, dout2}, {8'b0, exp_q2[0][23:0]});
        check("mon_sat2", {31'b0, sat2}, {31'b0, exp_q2[0][24]});
      end
      check("mon_ovf0", {31'b0, ovf0}, {31'b0, m_ovf0});
      check("mon_ovf2", {31'b0, ovf2}, {31'b0, m_ovf2});
      // Events taking effect on the coming rising edge.
      if (exp_q0.size() != 0 && dout_ready) begin
        void'(exp_q0.pop_front());
        void'(exp_q2.pop_front());
      end
      if (clear) begin
        m_sum = 0; m_n = 0; m_ovf0 = 1'b0; m_ovf2 = 1'b0;
      end else if (din_valid && exp_rdy) begin
        m_sum += longint'(din);
        m_n++;
        if (m_n == DUMP_LEN) begin
          e0 = expect_out(m_sum, 0);
          e2 = expect_out(m_sum, 2);
          exp_q0.push_back(e0);
          exp_q2.push_back(e2);
          m_ovf0 = m_ovf0 | e0[24];
          m_ovf2 = m_ovf2 | e2[24];
          m_sum = 0; m_n = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [23:0] v);
    bit done = 1'b0;
    din = v;
    din_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = rdy0;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got din_ready 0 expected 1 within 50 cycles at %0t", $time);
    end
  endtask

  typedef struct packed {
    logic [3:0][23:0] s;
    logic [23:0]      v0;
    logic             s0;
    logic             o0;
    logic [23:0]      v2;
    logic             s2;
    logic             o2;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] a, b, c, d,
                              input logic [23:0] v0, input logic s0, o0,
                              input logic [23:0] v2, input logic s2, o2);
    vec_t r;
    r.s[0] = a; r.s[1] = b; r.s[2] = c; r.s[3] = d;
    r.v0 = v0; r.s0 = s0; r.o0 = o0;
    r.v2 = v2; r.s2 = s2; r.o2 = o2;
    return r;
  endfunction

  vec_t tbl[7];

  initial begin
    rst = 1'b1; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    tbl[0] = mk(24'd1, 24'd2, 24'd3, 24'd4, 24'd10, 1'b0, 1'b0, 24'd2, 1'b0, 1'b0);
    tbl[1] = mk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
                24'h7FFFFF, 1'b1, 1'b1, 24'h7FFFFF, 1'b0, 1'b0);
    tbl[2] = mk(24'd1, 24'd1, 24'd1, 24'd1, 24'd4, 1'b0, 1'b1, 24'd1, 1'b0, 1'b0);
    tbl[3] = mk(24'h800000, 24'h800000, 24'h800000, 24'h800000,
                24'h800000, 1'b1, 1'b1, 24'h800000, 1'b0, 1'b0);
    tbl[4] = mk(24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC,
                24'hFFFFF6, 1'b0, 1'b1, 24'hFFFFFD, 1'b0, 1'b0);
    tbl[5] = mk(24'd1, 24'd2, 24'd3, 24'd4, 24'd10, 1'b0, 1'b1, 24'd2, 1'b0, 1'b0);
    tbl[6] = mk(24'd100, 24'hFFFFCE, 24'd25, 24'hFFFFB5, 24'd0, 1'b0, 1'b1, 24'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_valid", {31'b0, dv0}, 32'd0);
    check("reset_dout", {8'b0, dout0}, 32'd0);
    check("reset_din_ready", {31'b0, rdy0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table frames, back-to-back, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) send(tbl[i].s[k]);
      check("tbl_dout_valid", {31'b0, dv0}, 32'd1);
      check("tbl_dout0", {8'b0, dout0}, {8'b0, tbl[i].v0});
      check("tbl_sat0", {31'b0, sat0}, {31'b0, tbl[i].s0});
      check("tbl_ovf0", {31'b0, ovf0}, {31'b0, tbl[i].o0});
      check("tbl_dout2", {8'b0, dout2}, {8'b0, tbl[i].v2});
      check("tbl_sat2", {31'b0, sat2}, {31'b0, tbl[i].s2});
      check("tbl_ovf2", {31'b0, ovf2}, {31'b0, tbl[i].o2});
    end
    din_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: the frame-completing sample of the second frame stalls.
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(24'd1);
    for (int k = 0; k < 3; k++) send(24'd2);
    din = 24'd2;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", {31'b0, rdy0}, 32'd0);
      check("bp_hold_dout", {8'b0, dout0}, 32'd4);
      check("bp_hold_valid", {31'b0, dv0}, 32'd1);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'b0, rdy0}, 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    check("bp_no_bubble_valid", {31'b0, dv0}, 32'd1);
    check("bp_second_dout", {8'b0, dout0}, 32'd8);
    @(posedge clk); #1;

    // Clear mid-frame; the sample offered during clear is dropped.
    send(24'd7);
    send(24'd7);
    clear = 1'b1;
    din = 24'd9;
    @(negedge clk);
    check("clr_din_ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_ovf", {31'b0, ovf0}, 32'd0);
    for (int k = 0; k < 4; k++) send(24'd5);
    check("clr_dout0", {8'b0, dout0}, 32'd20);
    check("clr_dout2", {8'b0, dout2}, 32'd5);
    din_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       din = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
        1:       din = 24'($urandom);
        default: din = 24'($urandom_range(0, 200)) - 24'sd100;
      endcase
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      clear      = ($urandom_range(0, 29) == 0);
      @(posedge clk); #1;
    end
    din_valid = 1'b0; dout_ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between edges with a pending saturated result and a partial frame.
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(24'h7FFFFF);
    send(24'd1);
    send(24'd2);
    din_valid = 1'b0;
    check("pre_rst_valid", {31'b0, dv0}, 32'd1);
    check("pre_rst_ovf", {31'b0, ovf0}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, dv0}, 32'd0);
    check("async_rst_dout", {8'b0, dout0}, 32'd0);
    check("async_rst_sat", {31'b0, sat0}, 32'd0);
    check("async_rst_ovf", {31'b0, ovf0}, 32'd0);
    check("async_rst_ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dout_ready = 1'b1;
    send(24'd1); send(24'd2); send(24'd3); send(24'd4);
    check("post_rst_dout0", {8'b0, dout0}, 32'd10);
    check("post_rst_dout2", {8'b0, dout2}, 32'd2);
    check("post_rst_valid", {31'b0, dv0}, 32'd1);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
